// File: rtl/fwd_history_bypass.sv
// fwd_history_bypass
//   Operand forwarding for NPORTS register read ports. A shift-register
//   history keeps the last DEPTH register-file writebacks. Each port takes
//   the newest matching value from the live writeback or the history, and
//   otherwise falls back to the register-file read data. Resolution is
//   combinational with zero latency. Register 0 is never forwarded.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : synchronous active-high reset (clears history valids and hit counters)
//   flush      : invalidates every history entry; the same cycle's writeback is dropped
//   wb_we      : live writeback valid
//   wb_addr    : live writeback destination register
//   wb_data    : live writeback data
//   rd_addr    : per-port operand address, port p at [p*AW +: AW]
//   rd_regdata : per-port register-file read data, port p at [p*DW +: DW]
//   dout       : per-port resolved operand
//   fwd_hit    : per-port flag, 1 when dout comes from the live writeback or the history
//   fwd_src    : per-port source code, 4 bits each: 0 regfile, 1 live wb, 2+k history[k]
//   hit_cnt    : per-port saturating count of cycles with fwd_hit=1, CW bits each
module fwd_history_bypass #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int DEPTH  = 2,
  parameter int NPORTS = 2,
  parameter int CW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_addr,
  input  logic [DW-1:0]        wb_data,
  input  logic [NPORTS*AW-1:0] rd_addr,
  input  logic [NPORTS*DW-1:0] rd_regdata,
  output logic [NPORTS*DW-1:0] dout,
  output logic [NPORTS-1:0]    fwd_hit,
  output logic [NPORTS*4-1:0]  fwd_src,
  output logic [NPORTS*CW-1:0] hit_cnt
);

  logic          r_hist_v    [DEPTH];
  logic [AW-1:0] r_hist_addr [DEPTH];
  logic [DW-1:0] r_hist_data [DEPTH];
  logic [CW-1:0] r_hit_cnt   [NPORTS];

  logic          w_wb_cap;
  logic [AW-1:0] w_addr;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  // A writeback to r0 is never recorded, so history entries never hold r0.
  assign w_wb_cap = wb_we && (wb_addr != '0);

  // History valid bits: the only history state that reset and flush touch.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < DEPTH; k++) r_hist_v[k] <= 1'b0;
    end else begin
      r_hist_v[0] <= w_wb_cap;
      for (int k = 1; k < DEPTH; k++) r_hist_v[k] <= r_hist_v[k-1];
    end
  end

  // History address/data shift unconditionally; they only matter while valid.
  always_ff @(posedge clk) begin
    r_hist_addr[0] <= wb_addr;
    r_hist_data[0] <= wb_data;
    for (int k = 1; k < DEPTH; k++) begin
      r_hist_addr[k] <= r_hist_addr[k-1];
      r_hist_data[k] <= r_hist_data[k-1];
    end
  end

  // Per-port resolution: scan the history oldest-first so the newest match
  // overwrites the older ones, then let the live writeback override them all.
  always_comb begin
    dout    = rd_regdata;
    fwd_hit = '0;
    fwd_src = '0;
    w_addr  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_addr = rd_addr[p*AW +: AW];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_hist_v[k] && (r_hist_addr[k] == w_addr) && (w_addr != '0)) begin
          dout[p*DW +: DW] = r_hist_data[k];
          fwd_hit[p]       = 1'b1;
          fwd_src[p*4 +: 4] = 4'(k + 2);
        end
      end
      if (wb_we && (wb_addr == w_addr) && (w_addr != '0)) begin
        dout[p*DW +: DW]  = wb_data;
        fwd_hit[p]        = 1'b1;
        fwd_src[p*4 +: 4] = 4'd1;
      end
    end
  end

  // Hit counters sample this cycle's combinational fwd_hit.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (rst) begin
        r_hit_cnt[p] <= '0;
      end else if (fwd_hit[p]) begin
        r_hit_cnt[p] <= sat_inc(r_hit_cnt[p]);
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int p = 0; p < NPORTS; p++) hit_cnt[p*CW +: CW] = r_hit_cnt[p];
  end

endmodule

// File: tb/tb_fwd_history_bypass.sv
module tb_fwd_history_bypass;
  localparam int DW = 32, AW = 5, DEPTH = 2, NP = 2, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst, flush, wb_we;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*DW-1:0]  rd_regdata;
  logic [NP*DW-1:0]  dout;
  logic [NP-1:0]     fwd_hit;
  logic [NP*4-1:0]   fwd_src;
  logic [NP*CW-1:0]  hit_cnt;

  int n_chk = 0;
  int n_fail = 0;

  fwd_history_bypass #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NPORTS(NP), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .rd_addr(rd_addr), .rd_regdata(rd_regdata), .dout(dout),
    .fwd_hit(fwd_hit), .fwd_src(fwd_src), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: list of recent writebacks, newest first, plus counters.
  typedef struct { bit v; logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t mh[$];
  int   mcnt[NP];

  function automatic void predict(input int p, output logic [DW-1:0] d, output int src);
    logic [AW-1:0] a;
    a   = rd_addr[p*AW +: AW];
    d   = rd_regdata[p*DW +: DW];
    src = 0;
    if (a == 0) return;
    if (wb_we && wb_addr == a) begin
      d = wb_data; src = 1; return;
    end
    foreach (mh[k]) begin
      if (mh[k].v && mh[k].a == a) begin
        d = mh[k].d; src = 2 + k; return;
      end
    end
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic cycle();
    bit h[NP];
    logic [DW-1:0] d;
    int s;
    ent_t e;
    for (int p = 0; p < NP; p++) begin
      predict(p, d, s);
      h[p] = (s != 0);
    end
    @(posedge clk);
    if (rst) begin
      foreach (mh[k]) mh[k].v = 0;
      for (int p = 0; p < NP; p++) mcnt[p] = 0;
    end else begin
      for (int p = 0; p < NP; p++) if (h[p] && mcnt[p] < CMAX) mcnt[p]++;
      if (flush) begin
        foreach (mh[k]) mh[k].v = 0;
      end else begin
        e.v = wb_we && (wb_addr != 0); e.a = wb_addr; e.d = wb_data;
        mh.push_front(e);
        void'(mh.pop_back());
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    rd_addr = 0; rd_regdata = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; wb_we = 1; wb_addr = 3; wb_data = 32'hDEAD;
    rd_addr = {5'd3, 5'd3}; rd_regdata = 0;
    cycle(); cycle();
    #1;
    for (int p = 0; p < NP; p++) begin
      n_chk++;
      if (hit_cnt[p*CW +: CW] !== 0) begin
        n_fail++; $display("FAIL reset_hit_cnt[%0d]: got %0d want 0", p, hit_cnt[p*CW +: CW]);
      end
    end
    idle_inputs();
    rd_addr[4:0] = 3; rd_regdata[31:0] = 32'h11;
    #1;
    n_chk++;
    if (dout[31:0] !== 32'h11 || fwd_hit[0] !== 1'b0 || fwd_src[3:0] !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_read: dout=%h hit=%b src=%0d want 11/0/0", dout[31:0], fwd_hit[0], fwd_src[3:0]);
    end
    cycle();
  endtask

  task automatic test_priority();
    idle_inputs();
    wb_we = 1; wb_addr = 5; wb_data = 32'hAAAA;
    cycle();
    wb_data = 32'hBBBB; rd_addr[4:0] = 5;
    #1;
    n_chk++;
    if (dout[31:0] !== 32'hBBBB || fwd_src[3:0] !== 4'd1 || fwd_hit[0] !== 1'b1) begin
      n_fail++; $display("FAIL prio_live: dout=%h src=%0d want BBBB/1", dout[31:0], fwd_src[3:0]);
    end
    cycle();
    wb_we = 0;
    #1;
    n_chk++;
    if (dout[31:0] !== 32'hBBBB || fwd_src[3:0] !== 4'd2 || fwd_hit[0] !== 1'b1) begin
      n_fail++; $display("FAIL prio_hist: dout=%h src=%0d want BBBB/2", dout[31:0], fwd_src[3:0]);
    end
    cycle();
  endtask

  task automatic test_aging();
    logic [DW-1:0] exp_d [4];
    int            exp_s [4];
    exp_d = '{32'h1234, 32'h1234, 32'h1234, 32'h0};
    exp_s = '{1, 2, 3, 0};
    idle_inputs();
    wb_we = 1; wb_addr = 7; wb_data = 32'h1234; rd_addr[9:5] = 7;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if (dout[63:32] !== exp_d[i] || int'(fwd_src[7:4]) != exp_s[i] || fwd_hit[1] !== (exp_s[i] != 0)) begin
        n_fail++;
        $display("FAIL aging_step%0d: dout=%h src=%0d want %h/%0d", i, dout[63:32], fwd_src[7:4], exp_d[i], exp_s[i]);
      end
      cycle();
      wb_we = 0; wb_addr = 0; wb_data = 0;
    end
  endtask

  task automatic test_r0();
    idle_inputs();
    wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF;
    #1;
    n_chk++;
    if (dout[31:0] !== 32'h0 || fwd_hit[0] !== 1'b0 || fwd_src[3:0] !== 4'd0) begin
      n_fail++; $display("FAIL r0_live: dout=%h hit=%b want 0/0", dout[31:0], fwd_hit[0]);
    end
    cycle();
    wb_we = 0; wb_data = 0;
    #1;
    n_chk++;
    if (dout[31:0] !== 32'h0 || fwd_hit[0] !== 1'b0) begin
      n_fail++; $display("FAIL r0_hist: dout=%h hit=%b want 0/0", dout[31:0], fwd_hit[0]);
    end
    wb_addr = 9; wb_data = 32'h9999; rd_addr[4:0] = 9; rd_regdata[31:0] = 32'h42;
    #1;
    n_chk++;
    if (dout[31:0] !== 32'h42 || fwd_hit[0] !== 1'b0 || fwd_src[3:0] !== 4'd0) begin
      n_fail++; $display("FAIL we0_nohit: dout=%h hit=%b want 42/0", dout[31:0], fwd_hit[0]);
    end
    cycle();
  endtask

  task automatic test_flush();
    idle_inputs();
    wb_we = 1; wb_addr = 4; wb_data = 32'h55;
    cycle();
    flush = 1; wb_data = 32'h66;
    cycle();
    idle_inputs();
    rd_addr[4:0] = 4; rd_regdata[31:0] = 32'h77;
    #1;
    n_chk++;
    if (dout[31:0] !== 32'h77 || fwd_hit[0] !== 1'b0 || fwd_src[3:0] !== 4'd0) begin
      n_fail++; $display("FAIL flush: dout=%h hit=%b want 77/0", dout[31:0], fwd_hit[0]);
    end
    cycle();
  endtask

  task automatic test_saturation();
    idle_inputs();
    rst = 1;
    cycle();
    rst = 0; wb_we = 1; wb_addr = 6; rd_addr = {5'd1, 5'd6};
    for (int i = 0; i < 20; i++) begin
      wb_data = $urandom;
      #1;
      n_chk++;
      if (int'(hit_cnt[CW-1:0]) != mcnt[0] || int'(hit_cnt[2*CW-1:CW]) != mcnt[1]) begin
        n_fail++; $display("FAIL sat_step%0d: cnt0=%0d cnt1=%0d want %0d/%0d", i, hit_cnt[CW-1:0], hit_cnt[2*CW-1:CW], mcnt[0], mcnt[1]);
      end
      cycle();
    end
    #1;
    n_chk++;
    if (hit_cnt[CW-1:0] !== 4'd15 || hit_cnt[2*CW-1:CW] !== 4'd0) begin
      n_fail++; $display("FAIL sat_final: cnt0=%0d cnt1=%0d want 15/0", hit_cnt[CW-1:0], hit_cnt[2*CW-1:CW]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int s;
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      flush   = ($urandom_range(0, 19) == 0);
      wb_we   = $urandom_range(0, 1);
      wb_addr = AW'($urandom_range(0, 7));
      wb_data = $urandom;
      for (int p = 0; p < NP; p++) begin
        rd_addr[p*AW +: AW]    = AW'($urandom_range(0, 7));
        rd_regdata[p*DW +: DW] = $urandom;
      end
      #1;
      for (int p = 0; p < NP; p++) begin
        predict(p, d, s);
        n_chk++;
        if (dout[p*DW +: DW] !== d || int'(fwd_src[p*4 +: 4]) != s || fwd_hit[p] !== (s != 0)
            || int'(hit_cnt[p*CW +: CW]) != mcnt[p]) begin
          n_fail++;
          $display("FAIL rand%0d_p%0d: dout=%h src=%0d hit=%b cnt=%0d want %h/%0d/%0d", i, p,
                   dout[p*DW +: DW], fwd_src[p*4 +: 4], fwd_hit[p], hit_cnt[p*CW +: CW], d, s, mcnt[p]);
        end
      end
      cycle();
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mh.push_back('{v: 0, a: '0, d: '0});
    for (int p = 0; p < NP; p++) mcnt[p] = 0;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_priority();
    test_aging();
    test_r0();
    test_flush();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
